// File: rtl/regfile_pkg.sv
// Shared constants for the decoded register file: default data and address
// widths, and the register count derived from the address width.
package regfile_pkg;

    localparam int DEFAULT_DATA_W   = 32;
    localparam int DEFAULT_ADDR_W   = 4;
    localparam int DEFAULT_NUM_REGS = 2 ** DEFAULT_ADDR_W;

endpackage : regfile_pkg

// File: rtl/onehot_decoder.sv
// Binary-to-one-hot decoder of any address width. With en low the output is
// all zeros, otherwise exactly the bit selected by addr is set.
module onehot_decoder #(
    parameter int ADDR_W = 4
) (
    input  logic                 en,
    input  logic [ADDR_W-1:0]    addr,
    output logic [2**ADDR_W-1:0] onehot
);

    // Clear every select line, then raise the addressed one when enabled
    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[addr] = 1'b1;
        end
    end

endmodule : onehot_decoder

// File: rtl/regfile_decoded.sv
// Register file with one write port, two read ports, a per-register busy
// scoreboard (reserve at issue, release at write-back), optional same-cycle
// write-to-read bypass and an optional hardwired zero register.
module regfile_decoded
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we,
    input  logic [ADDR_W-1:0]    waddr,
    input  logic [DATA_W-1:0]    wdata,
    input  logic [ADDR_W-1:0]    raddr1,
    input  logic [ADDR_W-1:0]    raddr2,
    output logic [DATA_W-1:0]    rdata1,
    output logic [DATA_W-1:0]    rdata2,
    input  logic                 rsv,
    input  logic [ADDR_W-1:0]    rsv_addr,
    output logic                 busy1,
    output logic                 busy2,
    output logic [2**ADDR_W-1:0] busy_vec
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    // Register 0 is masked out of both write and reserve selects when it is
    // hardwired, so it never changes and its busy bit stays 0 after reset.
    localparam logic [NUM_REGS-1:0] ZERO_MASK =
        (ZERO_REG != 0) ? NUM_REGS'(1) : '0;

    logic [NUM_REGS-1:0] wsel;
    logic [NUM_REGS-1:0] rsel;
    logic [NUM_REGS-1:0] wselEff;
    logic [NUM_REGS-1:0] rselEff;

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    logic                bypassHit1;
    logic                bypassHit2;

    onehot_decoder #(.ADDR_W(ADDR_W)) u_wsel_dec (
        .en     (we),
        .addr   (waddr),
        .onehot (wsel)
    );

    onehot_decoder #(.ADDR_W(ADDR_W)) u_rsel_dec (
        .en     (rsv),
        .addr   (rsv_addr),
        .onehot (rsel)
    );

    assign wselEff = wsel & ~ZERO_MASK;
    assign rselEff = rsel & ~ZERO_MASK;

    // Each selected register loads the write data; reset clears the whole array
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wselEff[i]) begin
                    regs_q[i] <= wdata;
                end
            end
        end
    end

    // Scoreboard next state: a new reservation beats a same-cycle release
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rselEff[i]) begin
                busy_d[i] = 1'b1;
            end else if (wselEff[i]) begin
                busy_d[i] = 1'b0;
            end
        end
    end

    // Busy bits register the scoreboard next state, cleared on reset
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign bypassHit1 = (BYPASS != 0) && we && (waddr == raddr1);
    assign bypassHit2 = (BYPASS != 0) && we && (waddr == raddr2);

    // Read muxes: zero register first, then forwarded write data, then storage
    always_comb begin
        rdata1 = regs_q[raddr1];
        if ((ZERO_REG != 0) && (raddr1 == '0)) begin
            rdata1 = '0;
        end else if (bypassHit1) begin
            rdata1 = wdata;
        end
        rdata2 = regs_q[raddr2];
        if ((ZERO_REG != 0) && (raddr2 == '0)) begin
            rdata2 = '0;
        end else if (bypassHit2) begin
            rdata2 = wdata;
        end
    end

    assign busy1    = busy_q[raddr1];
    assign busy2    = busy_q[raddr2];
    assign busy_vec = busy_q;

endmodule : regfile_decoded

// File: tb/tb_regfile_decoded.sv
// Scoreboard bench for regfile_decoded. The stimulus thread drives each cycle
// just after the rising edge and queues what the outputs must show in that
// cycle; a monitor on the falling edge pops and compares every queued entry.
// Instance dut uses the defaults (16 regs, bypass on); dut2 has 32 registers
// and bypass off.
module tb_regfile_decoded;

    typedef enum int {
        SEL_RDATA1,
        SEL_RDATA2,
        SEL_BUSY1,
        SEL_BUSY2,
        SEL_BUSYVEC,
        SEL2_RDATA1,
        SEL2_RDATA2,
        SEL2_BUSYVEC
    } sigSel_e;

    typedef struct {
        sigSel_e     sel;
        logic [31:0] exp;
        string       name;
    } expect_t;

    expect_t sbQueue[$];
    int      compared   = 0;
    int      mismatched = 0;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;

    logic        we = 1'b0;
    logic [3:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  raddr1 = '0;
    logic [3:0]  raddr2 = '0;
    logic        rsv = 1'b0;
    logic [3:0]  rsvAddr = '0;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic        busy1;
    logic        busy2;
    logic [15:0] busyVec;

    logic        we2 = 1'b0;
    logic [4:0]  waddr2 = '0;
    logic [31:0] wdata2 = '0;
    logic [4:0]  raddr21 = '0;
    logic [4:0]  raddr22 = '0;
    logic        rsv2 = 1'b0;
    logic [4:0]  rsvAddr2 = '0;
    logic [31:0] rdata21;
    logic [31:0] rdata22;
    logic        busy21;
    logic        busy22;
    logic [31:0] busyVec2;

    always #5 clk = ~clk;

    regfile_decoded dut (
        .clk      (clk),
        .reset    (reset),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .raddr1   (raddr1),
        .raddr2   (raddr2),
        .rdata1   (rdata1),
        .rdata2   (rdata2),
        .rsv      (rsv),
        .rsv_addr (rsvAddr),
        .busy1    (busy1),
        .busy2    (busy2),
        .busy_vec (busyVec)
    );

    regfile_decoded #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) dut2 (
        .clk      (clk),
        .reset    (reset),
        .we       (we2),
        .waddr    (waddr2),
        .wdata    (wdata2),
        .raddr1   (raddr21),
        .raddr2   (raddr22),
        .rdata1   (rdata21),
        .rdata2   (rdata22),
        .rsv      (rsv2),
        .rsv_addr (rsvAddr2),
        .busy1    (busy21),
        .busy2    (busy22),
        .busy_vec (busyVec2)
    );

    // Queue an expected output value for the current cycle
    task automatic pushExpect(input sigSel_e s, input logic [31:0] e, input string n);
        expect_t item;
        item.sel  = s;
        item.exp  = e;
        item.name = n;
        sbQueue.push_back(item);
    endtask

    // Advance to just after the next rising edge and drive the main instance
    task automatic applyStimulus(input logic weV, input logic [3:0] waV,
                                 input logic [31:0] wdV, input logic rsvV,
                                 input logic [3:0] rsvAV, input logic [3:0] r1,
                                 input logic [3:0] r2);
        @(posedge clk);
        #1;
        we      = weV;
        waddr   = waV;
        wdata   = wdV;
        rsv     = rsvV;
        rsvAddr = rsvAV;
        raddr1  = r1;
        raddr2  = r2;
        we2     = 1'b0;
        rsv2    = 1'b0;
    endtask

    // Compare one scoreboard entry against the live DUT outputs
    task automatic checkOutput(input expect_t item);
        logic [31:0] act;
        case (item.sel)
            SEL_RDATA1:   act = rdata1;
            SEL_RDATA2:   act = rdata2;
            SEL_BUSY1:    act = {31'b0, busy1};
            SEL_BUSY2:    act = {31'b0, busy2};
            SEL_BUSYVEC:  act = {16'b0, busyVec};
            SEL2_RDATA1:  act = rdata21;
            SEL2_RDATA2:  act = rdata22;
            default:      act = busyVec2;
        endcase
        compared++;
        if (act !== item.exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", item.name, act, item.exp);
        end
    endtask

    // Monitor: drain all expectations queued for this cycle
    always @(negedge clk) begin
        while (sbQueue.size() > 0) begin
            checkOutput(sbQueue.pop_front());
        end
    end

    function automatic logic [31:0] sweepVal(input int i);
        return (i == 0) ? 32'h0 : 32'(i * 32'h11);
    endfunction

    initial begin
        int waitCycles;

        // Reset overrides a simultaneous write
        reset = 1'b1;
        applyStimulus(1'b1, 4'd5, 32'h0000_DEAD, 1'b1, 4'd5, 4'd5, 4'd5);
        applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd5, 4'd5);
        reset = 1'b0;
        applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd5, 4'd6);
        pushExpect(SEL_RDATA1,   32'h0, "reset_rdata1");
        pushExpect(SEL_BUSYVEC,  32'h0, "reset_busyvec");
        pushExpect(SEL2_BUSYVEC, 32'h0, "reset_busyvec2");

        // Write reg 3: bypass on main instance, old value on dut2
        applyStimulus(1'b1, 4'd3, 32'h1234_5678, 1'b0, 4'd0, 4'd3, 4'd3);
        we2 = 1'b1; waddr2 = 5'd3; wdata2 = 32'h1234_5678; raddr21 = 5'd3;
        pushExpect(SEL_RDATA1,  32'h1234_5678, "bypass_rdata1");
        pushExpect(SEL_RDATA2,  32'h1234_5678, "bypass_rdata2");
        pushExpect(SEL2_RDATA1, 32'h0,         "nobypass_old");
        applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd3, 4'd3);
        pushExpect(SEL_RDATA1,  32'h1234_5678, "write_rdata1");
        pushExpect(SEL_RDATA2,  32'h1234_5678, "write_rdata2");
        pushExpect(SEL2_RDATA1, 32'h1234_5678, "nobypass_after");

        // Reserve reg 7, then release it with a write-back
        applyStimulus(1'b0, 4'd0, 32'h0, 1'b1, 4'd7, 4'd7, 4'd3);
        pushExpect(SEL_BUSY1, 32'h0, "rsv_not_bypassed");
        applyStimulus(1'b1, 4'd7, 32'h0000_0077, 1'b0, 4'd0, 4'd7, 4'd3);
        pushExpect(SEL_BUSY1,   32'h1,      "rsv7_busy1");
        pushExpect(SEL_BUSY2,   32'h0,      "rsv7_busy2_other");
        pushExpect(SEL_BUSYVEC, 32'h0080,   "rsv7_busyvec");
        applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd7, 4'd7);
        pushExpect(SEL_BUSYVEC, 32'h0,      "release7_busyvec");
        pushExpect(SEL_RDATA1,  32'h77,     "release7_data");

        // Reserve reg 9, then reserve plus write-back in the same cycle
        applyStimulus(1'b0, 4'd0, 32'h0, 1'b1, 4'd9, 4'd9, 4'd9);
        applyStimulus(1'b1, 4'd9, 32'h0000_00AA, 1'b1, 4'd9, 4'd9, 4'd9);
        pushExpect(SEL_BUSYVEC, 32'h0200, "rsv9_busyvec");
        applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd9, 4'd9);
        pushExpect(SEL_BUSYVEC, 32'h0200, "rsvwins_busyvec");
        pushExpect(SEL_BUSY2,   32'h1,    "rsvwins_busy2");
        pushExpect(SEL_RDATA1,  32'hAA,   "rsvwins_data");

        // Zero register ignores write and reserve, even with bypass
        applyStimulus(1'b1, 4'd0, 32'h0000_FFFF, 1'b1, 4'd0, 4'd0, 4'd9);
        pushExpect(SEL_RDATA1, 32'h0, "zero_same_cycle");
        applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd0, 4'd0);
        pushExpect(SEL_RDATA1,  32'h0,    "zero_next_cycle");
        pushExpect(SEL_BUSYVEC, 32'h0200, "zero_busyvec");

        // Sweep every address on the main instance
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 4'(i), sweepVal(i), 1'b0, 4'd0, 4'd0, 4'd0);
        end
        applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd0, 4'd15);
        pushExpect(SEL_BUSYVEC, 32'h0, "sweep_busyvec");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'(i), 4'(15 - i));
            pushExpect(SEL_RDATA1, sweepVal(i),      $sformatf("sweep16_r1_%0d", i));
            pushExpect(SEL_RDATA2, sweepVal(15 - i), $sformatf("sweep16_r2_%0d", 15 - i));
        end

        // Sweep every address on the 32-register instance
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd0, 4'd0);
            we2 = 1'b1; waddr2 = 5'(i); wdata2 = sweepVal(i);
        end
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd0, 4'd0);
            raddr21 = 5'(i); raddr22 = 5'(31 - i);
            pushExpect(SEL2_RDATA1, sweepVal(i),      $sformatf("sweep32_r1_%0d", i));
            pushExpect(SEL2_RDATA2, sweepVal(31 - i), $sformatf("sweep32_r2_%0d", 31 - i));
        end

        // Reset in the middle: busy bit set, write in flight
        applyStimulus(1'b0, 4'd0, 32'h0, 1'b1, 4'd4, 4'd4, 4'd3);
        applyStimulus(1'b1, 4'd4, 32'h0000_0055, 1'b0, 4'd0, 4'd4, 4'd3);
        pushExpect(SEL_BUSYVEC, 32'h0010, "midrst_pre_busyvec");
        reset = 1'b1;
        applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd4, 4'd3);
        reset = 1'b0;
        pushExpect(SEL_BUSYVEC,  32'h0, "midrst_busyvec");
        pushExpect(SEL_RDATA1,   32'h0, "midrst_lost_write");
        pushExpect(SEL_RDATA2,   32'h0, "midrst_reg3");
        pushExpect(SEL2_RDATA2,  32'h0, "midrst_dut2");

        // Let the monitor drain the queue, bounded
        waitCycles = 0;
        while (sbQueue.size() > 0 && waitCycles < 10) begin
            @(posedge clk);
            waitCycles++;
        end
        @(posedge clk);
        if (sbQueue.size() > 0) begin
            mismatched++;
            $display("[TB] FAIL drain_timeout: got %0d pending entries expected 0", sbQueue.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_regfile_decoded

// File: doc/regfile_decoded.md
Name: regfile_decoded

Overview:
Parametrised general-purpose register file for the datapath: one write port, two read ports, and an internal one-hot write-select decoder generalised to any address width.
Adds a per-register busy scoreboard: issue logic marks a destination pending, and the write-back clears it.
Also adds optional write-to-read bypass and an optional hardwired zero register.
Sits between decode (read and reserve) and write-back (write and release).

Parameters:
DATA_W, 32, width of each register and of the data ports.
ADDR_W, 4, register address width; NUM_REGS = 2**ADDR_W (derived, not overridable).
ZERO_REG, 1, if 1 then register 0 always reads 0, and writes or reservations to it are ignored.
BYPASS, 1, if 1 a same-cycle write is forwarded to the read ports.

Ports:
clk  in  1  single clock, all state updates on the rising edge.
reset  in  1  synchronous, active-high reset.
we  in  1  write enable from write-back.
waddr  in  ADDR_W  write destination.
wdata  in  DATA_W  write data.
raddr1  in  ADDR_W  read port 1 address.
raddr2  in  ADDR_W  read port 2 address.
rdata1  out  DATA_W  read port 1 data (combinational).
rdata2  out  DATA_W  read port 2 data (combinational).
rsv  in  1  reserve request: mark rsv_addr busy.
rsv_addr  in  ADDR_W  register being reserved.
busy1  out  1  busy bit of raddr1 (combinational).
busy2  out  1  busy bit of raddr2 (combinational).
busy_vec  out  NUM_REGS  all busy bits, bit i = register i.

Behaviour:
- Reset (reset=1 at an edge): all registers become 0 and all busy bits become 0. It overrides we and rsv in the same cycle. After reset, rdata1/rdata2 read 0 and busy1/busy2/busy_vec are 0.
- Write decode: a one-hot vector wsel[NUM_REGS] = we ? (1 << waddr) : 0. Exactly zero or one bit is set; register i loads wdata on the edge when wsel[i]=1.
- Reserve decode: a one-hot vector rsel built the same way from rsv/rsv_addr.
- Write latency: a write is visible in the register on the next cycle.
- With BYPASS=1, if we=1 and waddr==raddrN (and the address is not the zero register), rdataN = wdata in the same cycle. With BYPASS=0, rdataN shows the old value until the edge.
- Busy update per register i, evaluated on each edge:
  - rsel[i]=1: busy[i] becomes 1. Reserve wins over a simultaneous write-back clear to the same register, because the newer issue owns it.
  - else if wsel[i]=1: busy[i] becomes 0.
  - else: busy[i] holds.
- busyN reflects registered state only. A clear at this edge is not bypassed into busyN in the same cycle.
- Write to a register that is not busy: data updates and busy stays 0. This is legal and not an error.
- ZERO_REG=1:
  - reads of address 0 return 0 regardless of bypass;
  - we or rsv targeting address 0 has no effect;
  - busy[0] is constant 0.
- Reset asserted mid-sequence (busy bits set, write in flight): everything clears. An in-flight write in the reset cycle is lost.
- All arithmetic is unsigned. Addresses never exceed NUM_REGS-1 by construction, so no out-of-range case exists.

Decomposition:
- Package regfile_pkg: default DATA_W/ADDR_W constants and a derived NUM_REGS constant.
- Sub-module onehot_decoder (parameter ADDR_W; in: en, addr; out: onehot[2**ADDR_W]) is the generalised successor of the fixed decoder. It is instantiated twice, once for wsel and once for rsel.
- Storage, bypass muxes and scoreboard live in regfile_decoded.

Test Plan:
- Reset with we=1, waddr=5, wdata=0xDEAD asserted in the same cycle -> after release, reading raddr1=5 gives 0; busy_vec=0.
- Write 0x1234_5678 to reg 3, then the next cycle read raddr1=3, raddr2=3 -> both ports give 0x12345678. Same-cycle read with BYPASS=1 -> 0x12345678; with BYPASS=0 -> old value 0.
- rsv=1, rsv_addr=7 -> next cycle busy_vec[7]=1 and busy1=1 when raddr1=7. Then we=1, waddr=7 -> next cycle busy_vec[7]=0 and reg 7 updated.
- Reg 9 busy; same cycle rsv=1, rsv_addr=9 and we=1, waddr=9, wdata=0xAA -> next cycle busy_vec[9]=1 (reserve wins) and reg 9 = 0xAA.
- ZERO_REG=1: we=1, waddr=0, wdata=0xFFFF plus rsv_addr=0 -> rdata1(raddr1=0)=0 in the same and following cycles; busy_vec[0]=0.
- Sweep waddr 0..15, each with distinct data i*0x11, then read all -> every register holds its own value (proves one-hot decode, no aliasing). Repeat with ADDR_W=5: 32 registers.
